// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: shares one memory port between the fetch and data masters, one transaction at a time, with timeout abort.
// Define ARB_ROUND_ROBIN_EN to replace data-over-fetch priority with round-robin arbitration.
module riscv_bus_arbiter #(
    parameter int DBUS_DATA_WIDTH = 64,
    parameter int DMEM_ADDR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_if_rd_en,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_if_addr,
    output logic [DBUS_DATA_WIDTH-1:0] o_if_rdata,
    output logic                       o_if_rdata_valid,
    input  logic                       i_d_wr_en,
    input  logic                       i_d_rd_en,
    input  logic [7:0]                 i_d_mask,
    input  logic [DMEM_ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DBUS_DATA_WIDTH-1:0] i_d_wdata,
    output logic [DBUS_DATA_WIDTH-1:0] o_d_rdata,
    output logic                       o_d_rdata_valid,
    output logic                       o_d_wr_ready,
    output logic                       o_bus_wr_en,
    output logic                       o_bus_rd_en,
    output logic [7:0]                 o_bus_mask,
    output logic [DMEM_ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DBUS_DATA_WIDTH-1:0] o_bus_wdata,
    input  logic [DBUS_DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                       i_bus_rdata_valid,
    input  logic                       i_bus_wr_ready,
    output logic                       o_bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] IDLE = 2'd0, GNT_IF = 2'd1, GNT_D = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic          err_q, err_d, ab_if_q, ab_if_d, ab_rd_q, ab_rd_d, ab_wr_q, ab_wr_d;
    logic          gnt_if, gnt_d, gnt, d_req, pick_d, start, done, tmo;

    assign gnt_if = state_q == GNT_IF;
    assign gnt_d  = state_q == GNT_D;
    assign gnt    = gnt_if | gnt_d;
    assign d_req  = i_d_wr_en | i_d_rd_en;
    // The abort cycle is not an arbitration cycle: the aborted master still holds its request.
    assign start  = state_q == IDLE && !err_q && (d_req || i_if_rd_en);
    assign done   = gnt & (op_wr_q ? i_bus_wr_ready : i_bus_rdata_valid);
    assign tmo    = gnt & ~done & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;
    assign pick_d = d_req & (~i_if_rd_en | ~last_d_q);
    always_ff @(posedge i_clk) begin
        if (i_rst) last_d_q <= 1'b0;
        else if (start) last_d_q <= pick_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d = start ? (pick_d ? GNT_D : GNT_IF) : (done | tmo) ? IDLE : state_q;
        op_wr_d = start ? pick_d & i_d_wr_en : op_wr_q;
        cnt_d   = start ? '0 : gnt ? cnt_q + 1'b1 : cnt_q;
        err_d   = tmo;
        ab_if_d = tmo & gnt_if;
        ab_rd_d = tmo & gnt_d & ~op_wr_q;
        ab_wr_d = tmo & gnt_d & op_wr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            err_q   <= 1'b0;
            ab_if_q <= 1'b0;
            ab_rd_q <= 1'b0;
            ab_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            err_q   <= err_d;
            ab_if_q <= ab_if_d;
            ab_rd_q <= ab_rd_d;
            ab_wr_q <= ab_wr_d;
        end
    end

    assign o_bus_rd_en      = gnt_if | (gnt_d & ~op_wr_q);
    assign o_bus_wr_en      = gnt_d & op_wr_q;
    assign o_bus_mask       = gnt_d ? i_d_mask : {8{gnt_if}};
    assign o_bus_addr       = gnt_d ? i_d_addr : gnt_if ? i_if_addr : '0;
    assign o_bus_wdata      = gnt_d ? i_d_wdata : '0;
    assign o_bus_err        = err_q;
    assign o_if_rdata       = gnt_if ? i_bus_rdata : '0;
    assign o_d_rdata        = gnt_d ? i_bus_rdata : '0;
    assign o_if_rdata_valid = (gnt_if & i_bus_rdata_valid) | ab_if_q;
    assign o_d_rdata_valid  = (gnt_d & ~op_wr_q & i_bus_rdata_valid) | ab_rd_q;
    assign o_d_wr_ready     = (gnt_d & op_wr_q & i_bus_wr_ready) | ab_wr_q;
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter: randomized rounds of fetch/data requests against a transaction-level model,
// with a scoreboard monitor checking grants and completions as the arbiter presents them.
module tb_riscv_bus_arbiter;
    localparam int TO  = 6;
    localparam int SIL = 1000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct { int cyc; logic wr; logic rd; logic [63:0] addr; logic [7:0] mask; logic [63:0] wdata; } gnt_t;
    typedef struct { int cyc; int m; logic wr; logic [63:0] data; logic err; } cpl_t;
    typedef struct { int lat; logic [63:0] data; } pl_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_if_rd_en = 0, i_d_wr_en = 0, i_d_rd_en = 0;
    logic [63:0] i_if_addr = 0, i_d_addr = 0, i_d_wdata = 0, i_bus_rdata = 0;
    logic [7:0]  i_d_mask = 0;
    logic        i_bus_rdata_valid = 0, i_bus_wr_ready = 0;
    logic [63:0] o_if_rdata, o_d_rdata, o_bus_addr, o_bus_wdata;
    logic        o_if_rdata_valid, o_d_rdata_valid, o_d_wr_ready, o_bus_wr_en, o_bus_rd_en, o_bus_err;
    logic [7:0]  o_bus_mask;

    riscv_bus_arbiter #(.DBUS_DATA_WIDTH(64), .DMEM_ADDR_WIDTH(64), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_rd_en(i_if_rd_en), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_rdata_valid(o_if_rdata_valid),
        .i_d_wr_en(i_d_wr_en), .i_d_rd_en(i_d_rd_en), .i_d_mask(i_d_mask), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_rdata(o_d_rdata), .o_d_rdata_valid(o_d_rdata_valid), .o_d_wr_ready(o_d_wr_ready),
        .o_bus_wr_en(o_bus_wr_en), .o_bus_rd_en(o_bus_rd_en), .o_bus_mask(o_bus_mask), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata), .i_bus_rdata_valid(i_bus_rdata_valid),
        .i_bus_wr_ready(i_bus_wr_ready), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0, errors = 0, checks = 0;
    gnt_t gq[$];
    cpl_t cq[$];
    pl_t  sq[$];
    bit   done_if, done_d, last_d = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Slave: answers each new grant after its planned latency; emits stray pulses while idle
    // and a decoy rdata_valid one cycle before a write's wr_ready.
    int   s_k, s_lat;
    bit   s_act = 0;
    logic [63:0] s_data;
    always @(posedge clk) begin
        pl_t p;
        #1;
        if (o_bus_rd_en || o_bus_wr_en) begin
            if (!s_act) begin
                s_act = 1; s_k = 0; s_lat = SIL; s_data = 0;
                if (sq.size() > 0) begin p = sq.pop_front(); s_lat = p.lat; s_data = p.data; end
            end else s_k++;
            i_bus_wr_ready    = o_bus_wr_en && s_k == s_lat;
            i_bus_rdata_valid = o_bus_rd_en ? s_k == s_lat : s_k + 1 == s_lat;
            i_bus_rdata       = (o_bus_rd_en && s_k == s_lat) ? s_data : i_bus_rdata_valid ? {$urandom, $urandom} : 64'd0;
        end else begin
            s_act = 0;
            i_bus_rdata_valid = $urandom_range(0, 3) == 0;
            i_bus_wr_ready    = $urandom_range(0, 3) == 0;
            i_bus_rdata       = {$urandom, $urandom};
        end
    end

    // Monitor: compares each grant start and each completion pulse against the queued expectations.
    bit prev_en = 0;
    always @(negedge clk) begin
        gnt_t g;
        cpl_t c;
        int   n, mo;
        bit   en;
        en = o_bus_rd_en | o_bus_wr_en;
        if (en && !prev_en) begin
            if (gq.size() == 0) check("gnt_unexpected", gq.size(), 1);
            else begin
                g = gq.pop_front();
                check("gnt_cycle", cyc, g.cyc);
                check("gnt_wr_en", o_bus_wr_en, g.wr);
                check("gnt_rd_en", o_bus_rd_en, g.rd);
                check("gnt_addr", o_bus_addr, g.addr);
                check("gnt_mask", o_bus_mask, g.mask);
                check("gnt_wdata", o_bus_wdata, g.wdata);
            end
        end
        prev_en = en;
        n = int'(o_if_rdata_valid) + int'(o_d_rdata_valid) + int'(o_d_wr_ready);
        if (n > 0) begin
            check("cpl_single", n, 1);
            mo = o_if_rdata_valid ? 0 : 1;
            if (mo == 0) done_if = 1; else done_d = 1;
            if (cq.size() == 0) check("cpl_unexpected", cq.size(), 1);
            else begin
                c = cq.pop_front();
                check("cpl_cycle", cyc, c.cyc);
                check("cpl_master", mo, c.m);
                check("cpl_is_write", o_d_wr_ready, c.wr);
                check("cpl_rdata", mo == 0 ? o_if_rdata : o_d_rdata, c.data);
                check("cpl_other_rdata", mo == 0 ? o_d_rdata : o_if_rdata, 64'd0);
                check("cpl_bus_err", o_bus_err, c.err);
                if (c.err) check("abort_bus_en", {o_bus_rd_en, o_bus_wr_en}, 0);
            end
        end else if (o_bus_err) check("err_without_cpl", o_bus_err, 1'b0);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Model: grant order by arbitration rule; each grant begins one cycle after its request is
    // visible in an idle cycle, ends at completion or after TO granted cycles (abort pulse), then
    // one idle cycle passes before the next grant.
    task automatic run_round(input bit rif, input bit dwe, input bit dre, input logic [63:0] ia, da, dwd,
                             input logic [7:0] dm, input int lif, ld, input logic [63:0] xif, xd);
        int ord[$];
        int t, e, m, lat;
        bit wr;
        if (rif && (dwe || dre)) begin
            if (RR && !last_d) begin ord.push_back(1); ord.push_back(0); end
            else if (RR) begin ord.push_back(0); ord.push_back(1); end
            else begin ord.push_back(1); ord.push_back(0); end
        end else if (dwe || dre) ord.push_back(1);
        else if (rif) ord.push_back(0);
        t = cyc + 1;
        foreach (ord[i]) begin
            m   = ord[i];
            wr  = m == 1 && dwe;
            lat = m == 1 ? ld : lif;
            gq.push_back('{t, wr, !wr, m == 1 ? da : ia, m == 1 ? dm : 8'hFF, m == 1 ? dwd : 64'd0});
            sq.push_back('{lat, m == 1 ? xd : xif});
            e = lat < TO ? t + lat : t + TO;
            cq.push_back('{e, m, wr, (lat < TO && !wr) ? (m == 1 ? xd : xif) : 64'd0, lat >= TO});
            t = e + 2;
            last_d = m == 1;
        end
        done_if = 0; done_d = 0;
        i_if_rd_en = rif; i_if_addr = ia;
        i_d_wr_en = dwe; i_d_rd_en = dre; i_d_addr = da; i_d_wdata = dwd; i_d_mask = dm;
        for (int c = 0; c < 200 && (i_if_rd_en || i_d_wr_en || i_d_rd_en); c++) begin
            tick(1);
            if (done_if) i_if_rd_en = 0;
            if (done_d) begin i_d_wr_en = 0; i_d_rd_en = 0; end
        end
        check("round_hang", {i_if_rd_en, i_d_wr_en | i_d_rd_en}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, l1, l2;
        bit rif, dq, dwe, dre;
        tick(3);
        check("rst_bus_rd_en", o_bus_rd_en, 0);
        check("rst_bus_wr_en", o_bus_wr_en, 0);
        check("rst_bus_err", o_bus_err, 0);
        check("rst_if_valid", o_if_rdata_valid, 0);
        check("rst_d_valid", o_d_rdata_valid, 0);
        check("rst_wr_ready", o_d_wr_ready, 0);
        check("rst_bus_addr", o_bus_addr, 0);
        check("rst_bus_mask", o_bus_mask, 0);
        rst = 0;
        tick(2);
        run_round(1, 0, 0, 64'h8000_0000, 0, 0, 0, 3, 0, 64'h1122_3344_5566_7788, 0);
        tick(1);
        run_round(1, 1, 0, 64'h8000_0100, 64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 2, 1, {$urandom, $urandom}, 0);
        tick(2);
        run_round(0, 0, 1, 0, 64'h0200_0000, 0, 8'hFF, 0, SIL, 0, {$urandom, $urandom});
        tick(1);
        run_round(0, 1, 1, 0, 64'h0000_4000, 64'h55AA, 8'hF0, 0, 2, 0, 0);
        repeat (6) run_round(1, 0, 1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 8'hFF, 0, 0,
                             {$urandom, $urandom}, {$urandom, $urandom});
        repeat (120) begin
            rif = $urandom_range(0, 1);
            dq  = $urandom_range(0, 1);
            if (!rif && !dq) rif = 1;
            k   = $urandom_range(0, 2);
            dwe = dq && k != 0;
            dre = dq && k != 1;
            l1  = $urandom_range(0, 7) == 0 ? SIL : $urandom_range(0, 3);
            l2  = $urandom_range(0, 7) == 0 ? SIL : $urandom_range(0, 3);
            run_round(rif, dwe, dre, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      8'($urandom), l1, l2, {$urandom, $urandom}, {$urandom, $urandom});
            tick($urandom_range(0, 2));
        end
        // Reset in the middle of a fetch grant against a silent slave.
        gq.push_back('{cyc + 1, 1'b0, 1'b1, 64'h8000_0400, 8'hFF, 64'd0});
        sq.push_back('{SIL, 64'd0});
        i_if_addr = 64'h8000_0400; i_if_rd_en = 1;
        tick(2);
        rst = 1; i_if_rd_en = 0;
        tick(1);
        check("midrst_bus_rd_en", o_bus_rd_en, 0);
        check("midrst_if_valid", o_if_rdata_valid, 0);
        rst = 0; last_d = 0;
        tick(20);
        run_round(1, 1, 0, 64'h8000_0800, 64'h8000_0010, 64'h1234, 8'h0F, 1, 1, {$urandom, $urandom}, 0);
        tick(5);
        check("grants_left", gq.size(), 0);
        check("cpls_left", cq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_bus_arbiter.md
Name: riscv_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core memory bus.
- Shares one memory port between the instruction-fetch master (read-only) and the data master (read/write with byte mask).
- The slave side has the same signal set as the router's data-memory port, so the arbiter's slave port feeds the router's core interface directly.
- Grants one transaction at a time, holds the grant until the slave completes it, and detects slave timeouts.

Parameters:
- DBUS_DATA_WIDTH, 64, data width on all ports.
- DMEM_ADDR_WIDTH, 64, address width on all ports.
- TIMEOUT_CYCLES, 255, granted cycles without completion before forced abort; must be >= 2.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-high.
- i_if_rd_en  input  1  fetch read request, held until o_if_rdata_valid.
- i_if_addr  input  DMEM_ADDR_WIDTH  fetch address.
- o_if_rdata  output  DBUS_DATA_WIDTH  fetch read data.
- o_if_rdata_valid  output  1  fetch completion pulse.
- i_d_wr_en  input  1  data write request, held until completion.
- i_d_rd_en  input  1  data read request, held until completion.
- i_d_mask  input  8  byte mask.
- i_d_addr  input  DMEM_ADDR_WIDTH  data address.
- i_d_wdata  input  DBUS_DATA_WIDTH  write data.
- o_d_rdata  output  DBUS_DATA_WIDTH  data read data.
- o_d_rdata_valid  output  1  data read completion pulse.
- o_d_wr_ready  output  1  data write completion pulse.
- o_bus_wr_en, o_bus_rd_en  output  1 each  slave requests.
- o_bus_mask  output  8  slave byte mask.
- o_bus_addr  output  DMEM_ADDR_WIDTH  slave address.
- o_bus_wdata  output  DBUS_DATA_WIDTH  slave write data.
- i_bus_rdata  input  DBUS_DATA_WIDTH  slave read data.
- i_bus_rdata_valid  input  1  slave read done.
- i_bus_wr_ready  input  1  slave write done.
- o_bus_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- States: IDLE, GNT_IF, GNT_D. The FSM state, the latched op type (read/write) and the timeout counter are registered.
- Reset: state IDLE, counter 0, o_bus_err 0. All o_bus_*, o_if_*, o_d_* outputs are 0 while in IDLE.
- IDLE transitions:
  - Data request pending (i_d_wr_en|i_d_rd_en): go to GNT_D.
  - Else i_if_rd_en: go to GNT_IF.
  - Else stay in IDLE.
  - Fixed priority: data beats fetch.
- Op latch: the op type is latched on the IDLE->grant edge. If i_d_wr_en and i_d_rd_en are both high, the op is a write.
- Latency: request sampled at edge N; o_bus_* asserted from cycle N+1 (one-cycle arbitration latency).
- Slave drive in GNT_IF / GNT_D:
  - o_bus_addr, o_bus_wdata and o_bus_mask are driven combinationally from the granted master's live inputs. The master must hold them stable.
  - o_bus_rd_en / o_bus_wr_en follow the latched op. For GNT_IF, o_bus_mask = 8'hFF and o_bus_wdata = 0.
- Completion:
  - A read completes on i_bus_rdata_valid; a write completes on i_bus_wr_ready. Completion is sampled only while granted.
  - On completion, i_bus_rdata_valid or i_bus_wr_ready is forwarded combinationally, in the same cycle, to the granted master only. i_bus_rdata goes to that master's rdata; the other master sees 0.
  - Next state is IDLE, so there is one idle bubble between transactions.
- Stray responses: i_bus_rdata_valid or i_bus_wr_ready arriving in IDLE is ignored and forwarded to nobody.
- Timeout counter:
  - Cleared on grant; increments each granted cycle without completion.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the next edge goes to IDLE, pulses o_bus_err, and pulses the granted master's completion with rdata = 0.
  - A registered abort pulse is acceptable. That abort cycle drives o_bus_* to 0.
- Master drops its request while granted: the grant is held anyway; the slave enables stay asserted from the latched op until completion or timeout.
- Reset mid-transaction: the FSM returns to IDLE at the next edge, slave enables deassert, and no completion is forwarded.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register (reset value: fetch). When both masters request in IDLE, the master not granted last wins; a single requester always wins.
- Undefined: fixed data-over-fetch priority as above, and no last-grant register.

Test Plan:
- Reset, then fetch read at addr 0x8000_0000; slave returns rdata_valid with 0x1122334455667788 three cycles after o_bus_rd_en -> o_if_rdata_valid pulses once with that data, o_d_rdata_valid stays 0, FSM is IDLE the next cycle.
- Data write (addr 0x8000_0010, wdata 0xDEAD_BEEF, mask 0x0F) and fetch request in the same cycle -> data granted first: o_bus_wr_en=1, o_bus_mask=0x0F. After wr_ready, one idle cycle, then the fetch is granted. With ARB_ROUND_ROBIN_EN and last grant = data, fetch is granted first instead.
- Continuous requests from both masters with a slave answering in 1 cycle -> fixed mode: fetch starves; round-robin: grants alternate D, IF, D, IF.
- Data read to 0x0200_0000 with the slave silent -> after TIMEOUT_CYCLES granted cycles: o_bus_err pulses, o_d_rdata_valid pulses with rdata 0, then IDLE.
- i_bus_rdata_valid pulsed in IDLE -> no o_*_rdata_valid. i_rst asserted mid-grant -> o_bus_rd_en=0 the next cycle, no completion pulse.
- Data request with both wr_en and rd_en high -> slave sees o_bus_wr_en=1, o_bus_rd_en=0; completes on i_bus_wr_ready only.
